// File: rtl/ctr_e.sv
// ctr_e: execute-stage control; registers D->E fields or a bubble, decodes ALU/writeback controls, counts bubbles.
module ctr_e #(
  parameter int CNT_W = 16,
  parameter logic [5:0] NOP_OP = 6'b000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_12,
  input  logic [5:0]       func_12,
  input  logic [4:0]       rs_12,
  input  logic [4:0]       rt_12,
  input  logic [4:0]       rd_12,
  input  logic             stall,
  output logic [5:0]       op_23,
  output logic [5:0]       func_23,
  output logic [4:0]       rs_E,
  output logic [4:0]       rt_E,
  output logic [4:0]       A3_E,
  output logic             RegWr_E,
  output logic [2:0]       ALUOp_E,
  output logic             ALUSrc_E,
  output logic [1:0]       Tnew_E,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic [5:0] op_q, op_d, func_q, func_d;
  logic [4:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic addu, subu, ori, lui, lw, sw, beq, jal;
  always_comb begin
    op_d   = stall ? NOP_OP : op_12;
    func_d = stall ? 6'd0 : func_12;
    rs_d   = stall ? 5'd0 : rs_12;
    rt_d   = stall ? 5'd0 : rt_12;
    rd_d   = stall ? 5'd0 : rd_12;
    cnt_d  = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      func_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      func_q <= func_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end
  // subu and lw share 6'b100011; subu only counts when op is R-type
  always_comb begin
    addu = (op_q == 6'b000000) && (func_q == 6'b100001);
    subu = (op_q == 6'b000000) && (func_q == 6'b100011);
    ori  = op_q == 6'b001101;
    lui  = op_q == 6'b001111;
    lw   = op_q == 6'b100011;
    sw   = op_q == 6'b101011;
    beq  = op_q == 6'b000100;
    jal  = op_q == 6'b000011;
    A3_E     = (addu || subu) ? rd_q : (ori || lui || lw) ? rt_q : jal ? 5'd31 : 5'd0;
    RegWr_E  = A3_E != 5'd0;
    ALUOp_E  = (addu || lw || sw) ? 3'b000 : (subu || beq) ? 3'b001 : ori ? 3'b010 : lui ? 3'b011 : 3'b100;
    ALUSrc_E = ori || lui || lw || sw;
    Tnew_E   = lw ? 2'd2 : (addu || subu || ori || lui) ? 2'd1 : 2'd0;
  end
  assign op_23      = op_q;
  assign func_23    = func_q;
  assign rs_E       = rs_q;
  assign rt_E       = rt_q;
  assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_ctr_e.sv
// tb_ctr_e: vector table, corner sequences and random stimulus against a mnemonic-level model; a CNT_W=2 copy shares the stimulus.
module tb_ctr_e;
  logic clk = 0, rst_n = 0, stall = 0;
  logic [5:0] op_12 = 0, func_12 = 0;
  logic [4:0] rs_12 = 0, rt_12 = 0, rd_12 = 0;
  logic [5:0] op_23, func_23, op_23b, func_23b;
  logic [4:0] rs_E, rt_E, A3_E, rs_Eb, rt_Eb, A3_Eb;
  logic RegWr_E, ALUSrc_E, RegWr_Eb, ALUSrc_Eb;
  logic [2:0] ALUOp_E, ALUOp_Eb;
  logic [1:0] Tnew_E, Tnew_Eb;
  logic [15:0] bubble_cnt;
  logic [1:0] bubble_cnt2;
  int errors = 0, checks = 0;
  logic [5:0] m_op, m_func;
  logic [4:0] m_rs, m_rt, m_rd;
  int m_cnt;

  always #5 clk = ~clk;

  ctr_e #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .op_12(op_12), .func_12(func_12), .rs_12(rs_12),
    .rt_12(rt_12), .rd_12(rd_12), .stall(stall), .op_23(op_23), .func_23(func_23), .rs_E(rs_E), .rt_E(rt_E),
    .A3_E(A3_E), .RegWr_E(RegWr_E), .ALUOp_E(ALUOp_E), .ALUSrc_E(ALUSrc_E), .Tnew_E(Tnew_E), .bubble_cnt(bubble_cnt));
  ctr_e #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .op_12(op_12), .func_12(func_12), .rs_12(rs_12),
    .rt_12(rt_12), .rd_12(rd_12), .stall(stall), .op_23(op_23b), .func_23(func_23b), .rs_E(rs_Eb), .rt_E(rt_Eb),
    .A3_E(A3_Eb), .RegWr_E(RegWr_Eb), .ALUOp_E(ALUOp_Eb), .ALUSrc_E(ALUSrc_Eb), .Tnew_E(Tnew_Eb), .bubble_cnt(bubble_cnt2));

  typedef struct {
    logic [5:0] op, func;
    logic [4:0] rs, rt, rd;
    logic [4:0] a3;
    logic rw;
    logic [2:0] aop;
    logic src;
    logic [1:0] tn;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode by instruction mnemonic
  task automatic decode(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rt, input logic [4:0] rd,
                        output logic [4:0] a3, output logic [2:0] aop, output logic src, output logic [1:0] tn);
    string m;
    if (op == 6'd0) m = (func == 6'h21) ? "addu" : (func == 6'h23) ? "subu" : (func == 6'h08) ? "jr" : "nop";
    else case (op)
      6'h0d: m = "ori"; 6'h0f: m = "lui"; 6'h23: m = "lw"; 6'h2b: m = "sw";
      6'h04: m = "beq"; 6'h02: m = "j"; 6'h03: m = "jal"; default: m = "nop";
    endcase
    a3 = 0; aop = 3'b100; src = 0; tn = 0;
    case (m)
      "addu": begin a3 = rd; aop = 3'b000; tn = 1; end
      "subu": begin a3 = rd; aop = 3'b001; tn = 1; end
      "ori":  begin a3 = rt; aop = 3'b010; src = 1; tn = 1; end
      "lui":  begin a3 = rt; aop = 3'b011; src = 1; tn = 1; end
      "lw":   begin a3 = rt; aop = 3'b000; src = 1; tn = 2; end
      "sw":   begin aop = 3'b000; src = 1; end
      "beq":  aop = 3'b001;
      "jal":  a3 = 5'd31;
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [4:0] a3; logic [2:0] aop; logic src; logic [1:0] tn;
    decode(m_op, m_func, m_rt, m_rd, a3, aop, src, tn);
    chk({tag, ".op_23"}, op_23, m_op);
    chk({tag, ".func_23"}, func_23, m_func);
    chk({tag, ".rs_E"}, rs_E, m_rs);
    chk({tag, ".rt_E"}, rt_E, m_rt);
    chk({tag, ".A3_E"}, A3_E, a3);
    chk({tag, ".RegWr_E"}, RegWr_E, a3 != 0);
    chk({tag, ".ALUOp_E"}, ALUOp_E, aop);
    chk({tag, ".ALUSrc_E"}, ALUSrc_E, src);
    chk({tag, ".Tnew_E"}, Tnew_E, tn);
    chk({tag, ".bubble_cnt"}, bubble_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    chk({tag, ".bubble_cnt2"}, bubble_cnt2, (m_cnt > 3) ? 3 : m_cnt);
    chk({tag, ".A3_E2"}, A3_Eb, a3);
  endtask

  task automatic apply(input logic r, input logic s, input logic [5:0] op, input logic [5:0] func,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input string tag);
    rst_n = r; stall = s; op_12 = op; func_12 = func; rs_12 = rs; rt_12 = rt; rd_12 = rd;
    @(posedge clk); #1;
    if (!r) begin m_op = 0; m_func = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0; end
    else if (s) begin m_op = 0; m_func = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_cnt++; end
    else begin m_op = op; m_func = func; m_rs = rs; m_rt = rt; m_rd = rd; end
    check_model(tag);
  endtask

  logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
  logic [5:0] funcs[4] = '{6'h21, 6'h23, 6'h08, 6'h15};

  initial begin
    vecs[0]  = '{6'h00, 6'h21, 5'd1, 5'd2, 5'd3,  5'd3,  1, 3'b000, 0, 2'd1};
    vecs[1]  = '{6'h23, 6'h00, 5'd4, 5'd8, 5'd0,  5'd8,  1, 3'b000, 1, 2'd2};
    vecs[2]  = '{6'h00, 6'h23, 5'd5, 5'd6, 5'd9,  5'd9,  1, 3'b001, 0, 2'd1};
    vecs[3]  = '{6'h03, 6'h00, 5'd0, 5'd0, 5'd0,  5'd31, 1, 3'b100, 0, 2'd0};
    vecs[4]  = '{6'h0d, 6'h05, 5'd7, 5'd0, 5'd12, 5'd0,  0, 3'b010, 1, 2'd1};
    vecs[5]  = '{6'h0d, 6'h05, 5'd7, 5'd7, 5'd12, 5'd7,  1, 3'b010, 1, 2'd1};
    vecs[6]  = '{6'h0f, 6'h00, 5'd0, 5'd5, 5'd0,  5'd5,  1, 3'b011, 1, 2'd1};
    vecs[7]  = '{6'h2b, 6'h00, 5'd3, 5'd4, 5'd6,  5'd0,  0, 3'b000, 1, 2'd0};
    vecs[8]  = '{6'h04, 6'h00, 5'd3, 5'd4, 5'd6,  5'd0,  0, 3'b001, 0, 2'd0};
    vecs[9]  = '{6'h02, 6'h11, 5'd3, 5'd4, 5'd6,  5'd0,  0, 3'b100, 0, 2'd0};
    vecs[10] = '{6'h00, 6'h08, 5'd31, 5'd0, 5'd0, 5'd0,  0, 3'b100, 0, 2'd0};
    vecs[11] = '{6'h3f, 6'h2a, 5'd1, 5'd2, 5'd3,  5'd0,  0, 3'b100, 0, 2'd0};
    vecs[12] = '{6'h00, 6'h15, 5'd1, 5'd2, 5'd3,  5'd0,  0, 3'b100, 0, 2'd0};
    vecs[13] = '{6'h00, 6'h21, 5'd1, 5'd2, 5'd0,  5'd0,  0, 3'b000, 0, 2'd1};
    m_op = 0; m_func = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0;
    // reset with random inputs, then first bubble
    apply(0, $urandom_range(0, 1), 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), "rst1");
    apply(0, $urandom_range(0, 1), 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), "rst2");
    chk("rst.ALUOp", ALUOp_E, 3'b100);
    chk("rst.cnt", bubble_cnt, 0);
    chk("rst.RegWr", RegWr_E, 0);
    apply(1, 1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, "post_rst_stall");
    chk("first_bubble.cnt", bubble_cnt, 1);
    // table-driven vectors
    foreach (vecs[i]) begin
      apply(1, 0, vecs[i].op, vecs[i].func, vecs[i].rs, vecs[i].rt, vecs[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("tab%0d.A3", i), A3_E, vecs[i].a3);
      chk($sformatf("tab%0d.RegWr", i), RegWr_E, vecs[i].rw);
      chk($sformatf("tab%0d.ALUOp", i), ALUOp_E, vecs[i].aop);
      chk($sformatf("tab%0d.ALUSrc", i), ALUSrc_E, vecs[i].src);
      chk($sformatf("tab%0d.Tnew", i), Tnew_E, vecs[i].tn);
      chk($sformatf("tab%0d.func_23", i), func_23, vecs[i].func);
    end
    // lw held in D across a 3-cycle stall
    begin
      int c0;
      c0 = bubble_cnt;
      for (int k = 0; k < 3; k++) begin
        apply(1, 1, 6'h23, 6'h00, 5'd2, 5'd8, 5'd0, "lw_stall");
        chk("lw_stall.op_23", op_23, 0);
        chk("lw_stall.RegWr", RegWr_E, 0);
      end
      chk("lw_stall.cnt_delta", bubble_cnt - c0, 3);
      apply(1, 0, 6'h23, 6'h00, 5'd2, 5'd8, 5'd0, "lw_enter");
      chk("lw_enter.op_23", op_23, 6'h23);
      chk("lw_enter.Tnew", Tnew_E, 2);
    end
    // saturation of the 2-bit counter, then reset during stall
    apply(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, "sat_rst");
    for (int k = 0; k < 6; k++) begin
      apply(1, 1, 6'h0d, 6'h01, 5'd1, 5'd1, 5'd1, "sat");
      chk($sformatf("sat%0d.cnt2", k), bubble_cnt2, (k < 3) ? k + 1 : 3);
    end
    apply(0, 1, 6'h0d, 6'h01, 5'd1, 5'd1, 5'd1, "rst_in_stall");
    chk("rst_in_stall.cnt2", bubble_cnt2, 0);
    chk("rst_in_stall.op_23", op_23b, 0);
    // random stimulus
    for (int k = 0; k < 400; k++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      apply($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, op, fn,
            5'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 5'($urandom), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctr_e.md
Name: ctr_e

Overview:
- Execute-stage control for the 5-stage MIPS pipeline (addu, subu, ori, lui, lw, sw, beq, j, jal, jr).
- Sits between the D-stage decode/hazard logic and the M-stage control.
- Registers the D→E instruction fields, or inserts a bubble when the hazard unit stalls.
- Drives ALU controls, the destination register and RegWr_E to the M stage.
- Publishes Tnew_E and operand register numbers for forwarding and stall logic.
- Keeps a saturating count of inserted bubbles for debug.

Parameters:
CNT_W, 16, width of the bubble counter
NOP_OP, 6'b000000, op value injected as a bubble (func also forced to 0; sll $0,$0,0)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
op_12  input  6  opcode of the instruction leaving D
func_12  input  6  func field of the instruction leaving D
rs_12  input  5  rs field from D
rt_12  input  5  rt field from D
rd_12  input  5  rd field from D
stall  input  1  hazard unit stall; 1 = load bubble into E this edge
op_23  output  6  registered opcode, forwarded to M-stage control
func_23  output  6  registered func, forwarded to M-stage control
rs_E  output  5  registered rs, for forwarding compare
rt_E  output  5  registered rt, for forwarding compare
A3_E  output  5  destination register of the E instruction
RegWr_E  output  1  E instruction writes the register file (A3_E != 0)
ALUOp_E  output  3  000 addu, 001 subu, 010 or, 011 lui (imm<<16), 100 pass/none
ALUSrc_E  output  1  1 = ALU B operand is the extended immediate
Tnew_E  output  2  cycles until the E result is available for forwarding
bubble_cnt  output  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Register update, on each rising clk, first rule that applies:
  - rst_n==0: op/func/rs/rt/rd registers <= 0; bubble_cnt <= 0.
  - stall==1: op/func/rs/rt/rd <= 0 (bubble); bubble_cnt increments by 1 unless all ones (saturate, no wrap).
  - Otherwise: op/func/rs/rt/rd <= op_12/func_12/rs_12/rt_12/rd_12.
- Latency: D fields appear on the E outputs one cycle after sampling.
- Outputs are combinational from the E registers only; no combinational path from any input.
- Decode from registered op/func:
  - R-type: op==0. addu func 100001; subu func 100011; jr func 001000.
  - I/J-type op: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - lw is identified by op only; subu requires op==0. The shared code 100011 must not alias.
- A3_E: rd for addu/subu; rt for ori/lui/lw; 5'd31 for jal; 0 for all other instructions, including bubbles and unknown opcodes.
- RegWr_E = (A3_E != 0). A write to $0 is a no-write.
- ALUOp_E: addu/lw/sw→000; subu/beq→001; ori→010; lui→011; all others→100.
- ALUSrc_E = 1 for ori, lui, lw, sw; 0 otherwise.
- Tnew_E: lw→2'd2; addu/subu/ori/lui→2'd1; jal→2'd0 (PC+8 produced in D); all others→2'd0.
- Reset value of every output is 0, except ALUOp_E=3'b100, because the all-zero instruction decodes as a bubble.
- Reset overrides stall. Reset in the middle of a stall clears the counter and the instruction.
- Unknown opcodes or funcs are treated as a bubble: RegWr_E=0, ALUOp_E=100, ALUSrc_E=0, Tnew_E=0. The raw op/func is still forwarded on op_23/func_23.
- stall held for N consecutive cycles inserts N bubbles. The instruction held in D enters E on the first non-stall edge.

Test Plan:
1. rst_n=0 for 2 cycles with random inputs, then rst_n=1 and stall=1 → after reset all outputs 0, ALUOp_E=100, bubble_cnt=0; next edge bubble_cnt=1.
2. addu op=0 func=100001 rs=1 rt=2 rd=3, stall=0 → next cycle A3_E=3, RegWr_E=1, ALUOp_E=000, ALUSrc_E=0, Tnew_E=1, op_23=0, func_23=100001.
3. lw op=100011 rt=8, then subu op=0 func=100011 rd=9 → cycle1: A3_E=8, Tnew_E=2, ALUSrc_E=1, ALUOp_E=000; cycle2: A3_E=9, Tnew_E=1, ALUOp_E=001, ALUSrc_E=0.
4. jal then ori with rt=0 → jal: A3_E=31, RegWr_E=1, Tnew_E=0; ori: A3_E=0, RegWr_E=0, ALUOp_E=010.
5. lw present in D, stall=1 for 3 cycles then 0 → three bubble cycles (RegWr_E=0, op_23=0), bubble_cnt increases by 3, lw appears in E on the 4th edge.
6. CNT_W=2, stall held for 6 cycles → bubble_cnt goes 1,2,3,3,3,3; a rst_n pulse while stall=1 → bubble_cnt=0 and op_23=0.
